// File: rtl/cv32e40p_discontinuity_checker_if.sv
// Instruction-stream observation bus and monitor outputs for the discontinuity checker.
interface cv32e40p_discontinuity_checker_if #(
  parameter int unsigned WWDL = 8
);
  localparam int unsigned CNT_W = $clog2(WWDL + 1);

  logic             instr_valid_i;
  logic [31:0]      instr_i;
  logic             alarm_clear_i;
  logic             alarm_o;
  logic             disc_o;
  logic [CNT_W-1:0] run_count_o;
  logic [7:0]       viol_count_o;
  logic [CNT_W-1:0] max_dist_o;

  modport master (
    output instr_valid_i, instr_i, alarm_clear_i,
    input  alarm_o, disc_o, run_count_o, viol_count_o, max_dist_o
  );

  modport slave (
    input  instr_valid_i, instr_i, alarm_clear_i,
    output alarm_o, disc_o, run_count_o, viol_count_o, max_dist_o
  );
endinterface

// File: rtl/cv32e40p_discontinuity_checker.sv
// Checks that a control-flow discontinuity reaches the core at least once every WWDL instructions.
// Optional longest-run tracking is enabled by defining CV32E40P_DISC_CHECK_MAXDIST_EN.
module cv32e40p_discontinuity_checker #(
  parameter int unsigned WWDL = 8
) (
  input logic clk,
  input logic rst,
  cv32e40p_discontinuity_checker_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WWDL + 1);
  localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(WWDL);
  localparam logic [CNT_W-1:0] RUN_INIT = CNT_W'(2);

  typedef enum logic {MONITOR, ALARM} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] run_q;
  logic             disc_q;
  logic [7:0]       viol_q;
  logic             is_disc, accepted, violation;

  logic [2:0] f3;
  assign f3 = bus.instr_i[15:13];

  always_comb begin
    is_disc = 1'b0;
    case (bus.instr_i[1:0])
      2'b01: is_disc = (f3 == 3'b001) || (f3 == 3'b101) || (f3 == 3'b110) || (f3 == 3'b111);
      2'b10: is_disc = (f3 == 3'b100) && (bus.instr_i[6:2] == 5'd0) && (bus.instr_i[11:7] != 5'd0);
      2'b11: is_disc = (bus.instr_i[6:2] == 5'b11000) || (bus.instr_i[6:2] == 5'b11011) ||
                       ((bus.instr_i[6:2] == 5'b11001) && (bus.instr_i[14:12] == 3'b000));
      default: is_disc = 1'b0;
    endcase
  end

  assign accepted  = bus.instr_valid_i && (bus.instr_i != '0);
  assign violation = accepted && !is_disc && (run_q == RUN_MAX);

  // Run counter resynchronises to zero on a violation so it never exceeds WWDL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= RUN_INIT;
      disc_q <= 1'b0;
      viol_q <= '0;
    end else begin
      disc_q <= accepted && is_disc;
      if (accepted) begin
        if (is_disc || violation) run_q <= '0;
        else                      run_q <= run_q + 1'b1;
      end
      if (violation && (viol_q != '1)) viol_q <= viol_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MONITOR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MONITOR: if (violation) state_d = ALARM;
      ALARM:   if (bus.alarm_clear_i && !violation) state_d = MONITOR;
      default: state_d = MONITOR;
    endcase
  end

  always_comb begin
    bus.alarm_o = (state_q == ALARM);
  end

  assign bus.disc_o       = disc_q;
  assign bus.run_count_o  = run_q;
  assign bus.viol_count_o = viol_q;

`ifdef CV32E40P_DISC_CHECK_MAXDIST_EN
  logic [CNT_W-1:0] max_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) max_q <= '0;
    else if (accepted && is_disc && (run_q > max_q)) max_q <= run_q;
  end

  assign bus.max_dist_o = max_q;
`else
  assign bus.max_dist_o = '0;
`endif
endmodule

// File: tb/tb_cv32e40p_discontinuity_checker.sv
// Directed bench for the discontinuity checker with WWDL=4.
module tb_cv32e40p_discontinuity_checker;
  localparam int unsigned WWDL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  cv32e40p_discontinuity_checker_if #(.WWDL(WWDL)) bus ();

  cv32e40p_discontinuity_checker #(.WWDL(WWDL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int exp_max(input int v);
`ifdef CV32E40P_DISC_CHECK_MAXDIST_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int a, input int d, input int r, input int v, input int m);
    chk({tag, ".alarm"}, 32'(bus.alarm_o), 32'(a));
    chk({tag, ".disc"},  32'(bus.disc_o), 32'(d));
    chk({tag, ".run"},   32'(bus.run_count_o), 32'(r));
    chk({tag, ".viol"},  32'(bus.viol_count_o), 32'(v));
    chk({tag, ".max"},   32'(bus.max_dist_o), 32'(m));
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic clr);
    bus.instr_valid_i = v;
    bus.instr_i       = ins;
    bus.alarm_clear_i = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.instr_valid_i = 1'b0;
    bus.instr_i       = '0;
    bus.alarm_clear_i = 1'b0;
    #1 rst = 1'b1;
    #2 chk_all("reset", 0, 0, 2, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // First window is WWDL-2 long: third nop violates
    step(1, 32'h13, 0); chk("w1.run", 32'(bus.run_count_o), 3);
    step(1, 32'h13, 0); chk_all("w1b", 0, 0, 4, 0, 0);
    step(1, 32'h13, 0); chk_all("w1.viol", 1, 0, 0, 1, 0);

    // Full legal run between two inserted jumps
    step(1, 32'h6F, 0); chk_all("jal1", 1, 1, 0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      step(1, 32'h13, 0);
      chk("run4.run", 32'(bus.run_count_o), 32'(i));
      chk("run4.disc", 32'(bus.disc_o), 0);
    end
    step(1, 32'h6F, 0); chk_all("jal2", 1, 1, 0, 1, exp_max(4));

    // Bubbles and invalid cycles leave the run untouched
    step(1, 32'h13, 0); chk("bub.r1", 32'(bus.run_count_o), 1);
    step(1, 32'h00, 0); chk("bub.zero", 32'(bus.run_count_o), 1);
    step(0, 32'h13, 0); chk("bub.inval", 32'(bus.run_count_o), 1);
    step(1, 32'h13, 0); chk("bub.r2", 32'(bus.run_count_o), 2);
    step(1, 32'h13, 0); chk("bub.r3", 32'(bus.run_count_o), 3);
    step(1, 32'h00, 0); chk("bub.zero2", 32'(bus.run_count_o), 3);
    step(1, 32'h13, 0); chk("bub.r4", 32'(bus.run_count_o), 4);
    step(0, 32'h13, 0); chk_all("bub.inval4", 1, 0, 4, 1, exp_max(4));
    step(0, 32'h6F, 0); chk_all("bub.invdisc", 1, 0, 4, 1, exp_max(4));
    step(1, 32'h6F, 0); chk_all("bub.jal", 1, 1, 0, 1, exp_max(4));

    // Decode corner cases
    step(1, 32'h13, 0);       chk("dec.pre", 32'(bus.run_count_o), 1);
    step(1, 32'h0000A001, 0); chk("dec.cj.run", 32'(bus.run_count_o), 0);
    chk("dec.cj.disc", 32'(bus.disc_o), 1);
    step(1, 32'h13, 0);       chk("dec.pre2", 32'(bus.run_count_o), 1);
    step(1, 32'h00008082, 0); chk("dec.cjr.run", 32'(bus.run_count_o), 0);
    chk("dec.cjr.disc", 32'(bus.disc_o), 1);
    step(1, 32'h00009002, 0); chk("dec.cebreak.run", 32'(bus.run_count_o), 1);
    chk("dec.cebreak.disc", 32'(bus.disc_o), 0);
    step(1, 32'h00001063, 0); chk("dec.bne.run", 32'(bus.run_count_o), 0);
    chk("dec.bne.disc", 32'(bus.disc_o), 1);
    step(1, 32'h000010E7, 0); chk("dec.jalrf3.run", 32'(bus.run_count_o), 1);
    chk("dec.jalrf3.disc", 32'(bus.disc_o), 0);

    // Clear in the same cycle as a violation loses; a later clear wins
    step(1, 32'h6F, 0);
    repeat (4) step(1, 32'h13, 0);
    chk("clr.pre.run", 32'(bus.run_count_o), 4);
    step(1, 32'h13, 1); chk_all("clr.viol", 1, 0, 0, 2, exp_max(4));
    step(1, 32'h13, 1); chk_all("clr.ok", 0, 0, 1, 2, exp_max(4));
    step(1, 32'h13, 1); chk_all("clr.mon", 0, 0, 2, 2, exp_max(4));

    // Back-to-back violations every WWDL+1 instructions
    step(1, 32'h13, 0);
    step(1, 32'h13, 0);
    step(1, 32'h13, 0); chk_all("b2b.v3", 1, 0, 0, 3, exp_max(4));
    for (int k = 4; k <= 5; k++) begin
      repeat (5) step(1, 32'h13, 0);
      chk("b2b.viol", 32'(bus.viol_count_o), 32'(k));
      chk("b2b.run", 32'(bus.run_count_o), 0);
      chk("b2b.alarm", 32'(bus.alarm_o), 1);
    end

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 0, 0, 2, 0, 0);
    @(negedge clk) rst = 1'b0;

    // Saturation: 260 violations from reset
    repeat (3 + 5 * 259) step(1, 32'h13, 0);
    chk_all("sat", 1, 0, 0, 255, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
